// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-back controller for the register file's single write port.
// Round-robin arbitration between the ALU and load paths (valid/ready), a
// registered write port, and a one-bit-per-register pending-write scoreboard
// that decode uses to stall on read-after-write hazards.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic [AW-1:0]      issue_rd,
    input  logic [AW-1:0]      rs1_addr,
    input  logic [AW-1:0]      rs2_addr,
    output logic               hazard1,
    output logic               hazard2,
    input  logic               alu_valid,
    input  logic [AW-1:0]      alu_rd,
    input  logic [DW-1:0]      alu_data,
    output logic               alu_ready,
    input  logic               mem_valid,
    input  logic [AW-1:0]      mem_rd,
    input  logic [DW-1:0]      mem_data,
    output logic               mem_ready,
    output logic               wt_en,
    output logic [AW-1:0]      wt_addr,
    output logic [DW-1:0]      wt_data,
    output logic [2**AW-1:0]   busy,
    output logic               wb_err
);

    localparam int NR = 2 ** AW;

    // Which requester wins the next contested cycle.
    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_t;

    prio_t            prio_reg;
    prio_t            prio_next;
    logic             grant_alu;
    logic             grant_mem;
    logic             accept;
    logic [AW-1:0]    acc_rd;
    logic [DW-1:0]    acc_data;

    logic             wt_en_reg;
    logic [AW-1:0]    wt_addr_reg;
    logic [DW-1:0]    wt_data_reg;
    logic [NR-1:0]    busy_reg;
    logic [NR-1:0]    busy_next;
    logic             wb_err_reg;
    logic             wb_err_next;

    // Priority pointer register; only moves after a contested grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_reg <= PRIO_ALU;
        end else begin
            prio_reg <= prio_next;
        end
    end

    // Grant decode: lone requester wins, contention goes to the priority
    // holder and hands priority to the loser. Nothing is granted in reset.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        prio_next = prio_reg;
        if (!rst) begin
            if (alu_valid && mem_valid) begin
                if (prio_reg == PRIO_ALU) begin
                    grant_alu = 1'b1;
                    prio_next = PRIO_MEM;
                end else begin
                    grant_mem = 1'b1;
                    prio_next = PRIO_ALU;
                end
            end else begin
                grant_alu = alu_valid;
                grant_mem = mem_valid;
            end
        end
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;
    assign accept    = grant_alu | grant_mem;
    assign acc_rd    = grant_mem ? mem_rd   : alu_rd;
    assign acc_data  = grant_mem ? mem_data : alu_data;

    // Registered write port; r0 writes complete the handshake without a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wt_en_reg   <= 1'b0;
            wt_addr_reg <= '0;
            wt_data_reg <= '0;
        end else begin
            wt_en_reg <= accept && (acc_rd != '0);
            if (accept) begin
                wt_addr_reg <= acc_rd;
                wt_data_reg <= acc_data;
            end
        end
    end

    // Per-register scoreboard next state: an issue sets the bit and beats a
    // simultaneous clear from the committing write; r0 is never tracked.
    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_busy
            if (gi == 0) begin : g_r0
                assign busy_next[gi] = 1'b0;
            end else begin : g_rn
                assign busy_next[gi] =
                    (issue_valid && (issue_rd == AW'(gi))) ||
                    (busy_reg[gi] && !(wt_en_reg && (wt_addr_reg == AW'(gi))));
            end
        end
    endgenerate

    // An accepted write-back to a nonzero register with no outstanding issue.
    assign wb_err_next = wb_err_reg ||
                         (accept && (acc_rd != '0) && !busy_reg[acc_rd]);

    // Scoreboard and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg   <= '0;
            wb_err_reg <= 1'b0;
        end else begin
            busy_reg   <= busy_next;
            wb_err_reg <= wb_err_next;
        end
    end

    assign hazard1 = busy_reg[rs1_addr] && (rs1_addr != '0);
    assign hazard2 = busy_reg[rs2_addr] && (rs2_addr != '0);
    assign wt_en   = wt_en_reg;
    assign wt_addr = wt_addr_reg;
    assign wt_data = wt_data_reg;
    assign busy    = busy_reg;
    assign wb_err  = wb_err_reg;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios followed by random traffic,
// checked against a per-register behavioural model with a write scoreboard.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        hazard1, hazard2;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic        mem_ready;
    logic        wt_en;
    logic [4:0]  wt_addr;
    logic [31:0] wt_data;
    logic [31:0] busy;
    logic        wb_err;

    rf_wb_arbiter #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .hazard1(hazard1), .hazard2(hazard2),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .wt_en(wt_en), .wt_addr(wt_addr), .wt_data(wt_data),
        .busy(busy), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct { bit [4:0] rd; bit [31:0] data; } req_t;
    typedef struct { bit [4:0] addr; bit [31:0] data; int cyc; } wr_t;

    req_t alu_q[$];
    req_t mem_q[$];
    wr_t  exp_q[$];
    int   obs_addr[$];
    int   obs_cyc[$];

    // Reference model state
    bit [31:0] m_busy = '0;
    bit        m_err = 1'b0;
    bit        m_prio = 1'b0;   // 0: ALU wins next contest
    bit        m_wen = 1'b0;
    bit [4:0]  m_waddr = '0;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every write-port pulse is matched against the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (wt_en === 1'b1) begin
            obs_addr.push_back(int'(wt_addr));
            obs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL wt_unexpected: actual addr=%0h data=%0h required=no write", wt_addr, wt_data);
            end else begin
                e = exp_q.pop_front();
                chk("wt_addr", 64'(wt_addr), 64'(e.addr));
                chk("wt_data", 64'(wt_data), 64'(e.data));
                chk("wt_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_chk++;
            $display("FAIL wt_missing: actual=no write required addr=%0h data=%0h", e.addr, e.data);
        end
    end

    task automatic drive_inputs();
        alu_valid = (alu_q.size() > 0);
        alu_rd    = alu_valid ? alu_q[0].rd   : 5'd0;
        alu_data  = alu_valid ? alu_q[0].data : 32'd0;
        mem_valid = (mem_q.size() > 0);
        mem_rd    = mem_valid ? mem_q[0].rd   : 5'd0;
        mem_data  = mem_valid ? mem_q[0].data : 32'd0;
    endtask

    task automatic model_reset();
        m_busy = '0; m_err = 1'b0; m_prio = 1'b0; m_wen = 1'b0; m_waddr = '0;
        exp_q.delete();
    endtask

    // One clock cycle: present inputs, check outputs before the edge, then
    // advance the model across the edge. Entered and left between edges.
    task automatic step();
        bit ga, gm, acc;
        bit [31:0] nb;
        req_t r;
        drive_inputs();
        ga = alu_valid && (!mem_valid || !m_prio);
        gm = mem_valid && (!alu_valid || m_prio);
        @(negedge clk);
        chk("alu_ready", 64'(alu_ready), 64'(ga));
        chk("mem_ready", 64'(mem_ready), 64'(gm));
        chk("hazard1", 64'(hazard1), 64'(m_busy[rs1_addr] && rs1_addr != 0));
        chk("hazard2", 64'(hazard2), 64'(m_busy[rs2_addr] && rs2_addr != 0));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("wb_err", 64'(wb_err), 64'(m_err));
        acc = ga || gm;
        r = '{rd: 5'd0, data: 32'd0};
        if (ga) r = alu_q.pop_front();
        else if (gm) r = mem_q.pop_front();
        nb = m_busy;
        if (m_wen) nb[m_waddr] = 1'b0;
        if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
        if (acc && r.rd != 0 && !m_busy[r.rd]) m_err = 1'b1;
        if (alu_valid && mem_valid) m_prio = ga;   // priority passes to the loser
        m_wen = acc && (r.rd != 0);
        m_waddr = r.rd;
        if (m_wen) exp_q.push_back('{addr: r.rd, data: r.data, cyc: cyc + 1});
        m_busy = nb;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit [4:0] rd);
        issue_valid = 1'b1; issue_rd = rd;
        step();
        issue_valid = 1'b0;
    endtask

    // Mid-cycle reset pulse covering two edges, released between edges.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_wt_en", 64'(wt_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd0);
        chk("rst_mem_ready", 64'(mem_ready), 64'd0);
        chk("rst_wb_err", 64'(wb_err), 64'd0);
        @(posedge clk); #1;
        chk("rst_alu_ready_edge", 64'(alu_ready), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    function automatic bit [4:0] pick_rd();
        int start;
        if ($urandom_range(1, 0) == 1 && m_busy != 0) begin
            start = $urandom_range(31, 0);
            for (int k = 0; k < 32; k++)
                if (m_busy[(start + k) % 32]) return 5'((start + k) % 32);
        end
        return 5'($urandom_range(31, 0));
    endfunction

    initial begin
        // Power-on reset values
        @(posedge clk); @(posedge clk); #1;
        chk("por_wt_en", 64'(wt_en), 64'd0);
        chk("por_wt_addr", 64'(wt_addr), 64'd0);
        chk("por_wt_data", 64'(wt_data), 64'd0);
        chk("por_busy", 64'(busy), 64'd0);
        chk("por_wb_err", 64'(wb_err), 64'd0);
        #2 rst = 1'b0;

        // Reset mid-stream while ALU holds a request and a write is in flight
        issue(5'd4);
        alu_q.push_back('{rd: 5'd4, data: 32'h1111_2222});
        alu_q.push_back('{rd: 5'd0, data: 32'h3333_4444});
        step();
        chk("pre_rst_wt_en", 64'(wt_en), 64'd1);
        drive_inputs();
        do_reset();
        #1;
        chk("rst_regrant", 64'(alu_ready), 64'd1);
        step();
        chk("r0_no_wt_en", 64'(wt_en), 64'd0);

        // Single write r5 = DEADBEEF
        rs1_addr = 5'd5;
        issue(5'd5);
        alu_q.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
        step();
        chk("single_wt_en", 64'(wt_en), 64'd1);
        chk("single_wt_addr", 64'(wt_addr), 64'd5);
        chk("single_wt_data", 64'(wt_data), 64'hDEAD_BEEF);
        chk("single_hazard_held", 64'(hazard1), 64'd1);
        step();
        chk("single_wt_en_drop", 64'(wt_en), 64'd0);
        chk("single_busy5", 64'(busy[5]), 64'd0);
        chk("single_hazard_drop", 64'(hazard1), 64'd0);
        chk("single_wb_err", 64'(wb_err), 64'd0);

        // Contention: grants alternate ALU/mem starting with ALU
        issue(5'd1); issue(5'd2); issue(5'd3);
        issue(5'd11); issue(5'd12); issue(5'd13);
        obs_addr.delete(); obs_cyc.delete();
        for (int i = 1; i <= 3; i++) begin
            alu_q.push_back('{rd: 5'(i), data: $urandom});
            mem_q.push_back('{rd: 5'(i + 10), data: $urandom});
        end
        for (int i = 0; i < 8; i++) step();
        chk("contend_count", 64'(obs_addr.size()), 64'd6);
        if (obs_addr.size() == 6) begin
            int order[6] = '{1, 11, 2, 12, 3, 13};
            for (int i = 0; i < 6; i++) begin
                chk("contend_order", 64'(obs_addr[i]), 64'(order[i]));
                if (i > 0) chk("contend_back2back", 64'(obs_cyc[i] - obs_cyc[i-1]), 64'd1);
            end
        end

        // Set/clear collision on r7
        issue(5'd7);
        alu_q.push_back('{rd: 5'd7, data: 32'h0000_0777});
        step();
        chk("coll_wt_addr", 64'(wt_addr), 64'd7);
        issue(5'd7);
        chk("coll_busy7", 64'(busy[7]), 64'd1);
        step();
        chk("coll_busy7_hold", 64'(busy[7]), 64'd1);
        alu_q.push_back('{rd: 5'd7, data: 32'h0000_0778});
        step(); step();
        chk("coll_busy7_clear", 64'(busy[7]), 64'd0);

        // r0 write and error flag
        mem_q.push_back('{rd: 5'd0, data: 32'hFFFF_FFFF});
        step();
        chk("r0_mem_wt_en", 64'(wt_en), 64'd0);
        chk("r0_mem_busy", 64'(busy), 64'd0);
        mem_q.push_back('{rd: 5'd9, data: 32'h0909_0909});
        step();
        chk("err_wt_en", 64'(wt_en), 64'd1);
        chk("err_set", 64'(wb_err), 64'd1);
        step(); step();
        chk("err_sticky", 64'(wb_err), 64'd1);

        // Back-to-back issue to r3, then two spaced write-backs
        do_reset();
        step();
        issue(5'd3); issue(5'd3);
        alu_q.push_back('{rd: 5'd3, data: 32'hAAAA_0003});
        step(); step();
        chk("b2b_busy3_clear", 64'(busy[3]), 64'd0);
        chk("b2b_no_err_yet", 64'(wb_err), 64'd0);
        alu_q.push_back('{rd: 5'd3, data: 32'hBBBB_0003});
        step();
        chk("b2b_err", 64'(wb_err), 64'd1);

        // Random traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (alu_q.size() < 2 && $urandom_range(2, 0) == 0)
                alu_q.push_back('{rd: pick_rd(), data: $urandom});
            if (mem_q.size() < 2 && $urandom_range(2, 0) == 0)
                mem_q.push_back('{rd: pick_rd(), data: $urandom});
            issue_valid = ($urandom_range(4, 0) < 2);
            issue_rd = 5'($urandom_range(31, 0));
            rs1_addr = 5'($urandom_range(31, 0));
            rs2_addr = pick_rd();
            step();
        end
        issue_valid = 1'b0;
        for (int c = 0; c < 20 && (alu_q.size() + mem_q.size()) > 0; c++) step();
        step(); step();
        chk("drain_requests", 64'(alu_q.size() + mem_q.size()), 64'd0);
        chk("drain_writes", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back controller for the 32x32 register file's single write port (write enable, write address, write data). It arbitrates between two write-back requesters, the ALU path and the load/memory path, using a valid/ready handshake with round-robin priority, and drives the register-file write port from registers. It also keeps a pending-write scoreboard, so decode can stall on read-after-write hazards until the register file holds the new value.

## Interface
- DW, 32, data width; equals register width
- AW, 5, register address width; 2**AW registers, register 0 hard-wired zero
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  decode issues an instruction that will write issue_rd
- issue_rd  in  AW  destination register of the issued instruction
- rs1_addr, rs2_addr  in  AW  source registers of the instruction in decode
- hazard1, hazard2  out  1  the matching source has a write outstanding (combinational)
- alu_valid  in  1  ALU write-back request
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU request accepted this cycle (combinational)
- mem_valid, mem_rd, mem_data, mem_ready  same as the alu_* ports, for the load path
- wt_en  out  1  register-file write enable (drives L_S)
- wt_addr  out  AW  register-file write address
- wt_data  out  DW  register-file write data
- busy  out  2**AW  scoreboard bitmap; bit 0 always 0
- wb_err  out  1  sticky flag: a write-back targeted a nonzero register that was not busy

## Operation
- Arbitration: at most one grant per cycle.
  - Only one requester valid: that requester is granted.
  - Both valid: the one holding priority is granted.
  - Priority pointer `prio`: 0 = ALU, 1 = mem. It updates only on a contested grant and moves to the loser.
- Ready rules: alu_ready = grant_alu and mem_ready = grant_mem. A ready output is never high while its valid is low.
- Requesters hold valid, rd and data stable until accepted. Dropping valid before acceptance is illegal.
- Accept (valid & ready at a rising edge):
  - wt_addr <= rd and wt_data <= data.
  - wt_en <= (rd != 0). A write to r0 completes the handshake but never pulses wt_en.
- No accept at an edge: wt_en <= 0; wt_addr and wt_data hold their previous values.
- Scoreboard:
  - Issue: issue_valid with issue_rd != 0 sets busy[issue_rd] at the edge.
  - Clear: at an edge where wt_en is 1, busy[wt_addr] clears, i.e. the same edge the register file commits the write.
  - Set and clear of the same register at the same edge: set wins, because a newer producer is now pending.
  - Issue to a register that is already busy is legal. The bit stays set and clears on the next write-back to that register (single-bit scoreboard, no count).
- Hazards: hazardN = busy[rsN_addr] & (rsN_addr != 0). They are purely combinational from the busy register.
- Error flag: wb_err sets at an accept edge when rd != 0 and busy[rd] == 0. It clears only on rst.

## Timing
- Reset values (async): wt_en=0, wt_addr=0, wt_data=0, busy=0, wb_err=0, prio=0 (ALU first). With rst high the ready outputs are 0 and no accept occurs.
- Latency:
  - Request accepted at edge N: wt_en is high during cycle N..N+1 and the register file writes at edge N+1.
  - busy clears at edge N+1, and the hazard drops in cycle N+1.
  - Sustained throughput: one write per cycle.
- Issue at edge M: busy and the hazard are visible from cycle M onward, so decode in the following cycle sees the stall.
- Reset asserted mid-operation: any pending wt_en is squashed immediately (no write occurs), the scoreboard is cleared, and held requests are re-arbitrated after rst falls.
- rst released between edges: the first accept can happen at the first rising edge after release.

## Test plan
- Reset: assert rst mid-stream with alu_valid=1 -> wt_en=0, busy=0, alu_ready=0 while rst is high; after release, ALU is granted at the first edge.
- Single write: issue rd=5, then ALU writes r5=0xDEADBEEF.
  - hazard1 is high for rs1=5 until edge N+1.
  - wt_en=1, wt_addr=5, wt_data=0xDEADBEEF for one cycle.
  - busy[5]=0 afterwards; wb_err=0.
- Contention: alu_valid and mem_valid held high with 3 requests each (rd 1..3 and 11..13) -> grants strictly alternate ALU, mem, ALU, ...; six consecutive wt_en pulses; no request lost.
- Set/clear collision: an ALU write to r7 is in flight (wt_en=1, wt_addr=7) while issue_rd=7 in the same cycle -> busy[7] remains 1 after the edge.
- r0 and error flag:
  - Write to rd=0 -> handshake completes, wt_en stays 0, busy unchanged.
  - mem write to rd=9 with busy[9]=0 -> wt_en=1, wb_err=1 and it stays 1 until rst.
- Back-to-back same register: issue r3 twice, then two write-backs to r3 -> busy[3] clears after the first write-back. wb_err is set by the second write-back, which targets a non-busy register.
